// File: rtl/decode_stage.sv
// Registered, handshaked instruction decoder between fetch and execute.
// One instruction per valid/ready transfer; control word appears one cycle after accept.
// Inserts issue bubbles after loads, latches FIN as a sticky halt, and flags illegal encodings.
module decode_stage #(
  parameter int unsigned IW       = 9,
  parameter int unsigned LD_STALL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  input  logic          cc_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_op,
  output logic          alu_opnd_sel,
  output logic [IW-7:0] opnd,
  output logic          rel_jump,
  output logic          rf_waddr_sel,
  output logic          rf_wval_sel,
  output logic          rf_reset_acc,
  output logic          rf_write_en,
  output logic          dm_write_en,
  output logic          done,
  output logic          sys_reset,
  output logic          illegal
);

  localparam int unsigned SCW = 4;

  localparam logic [3:0] ALU_PASS_ACC = 4'd0;
  localparam logic [3:0] ALU_PASS_VAL = 4'd1;
  localparam logic [3:0] ALU_DIST     = 4'd7;
  localparam logic [3:0] ALU_MIN      = 4'd8;
  localparam logic [3:0] ALU_UNK      = 4'd15;

  logic [2:0]     op;
  logic [2:0]     sub;
  logic [SCW-1:0] stall_cnt;
  logic           accept;

  logic [3:0] d_alu_op;
  logic       d_opnd_sel;
  logic       d_rel_jump;
  logic       d_waddr_sel;
  logic       d_wval_sel;
  logic       d_reset_acc;
  logic       d_write_en;
  logic       d_dm_write_en;
  logic       d_sys_reset;
  logic       d_illegal;
  logic       d_fin;
  logic       d_ld;

  assign op     = instr[IW-1:IW-3];
  assign sub    = instr[IW-4:IW-6];
  assign in_ready = !done && (stall_cnt == SCW'(0)) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;

  // Combinational decode of the instruction currently offered by fetch.
  always_comb begin
    d_alu_op      = ALU_PASS_ACC;
    d_opnd_sel    = 1'b0;
    d_rel_jump    = 1'b0;
    d_waddr_sel   = 1'b0;
    d_wval_sel    = 1'b0;
    d_reset_acc   = 1'b0;
    d_write_en    = 1'b0;
    d_dm_write_en = 1'b0;
    d_sys_reset   = 1'b0;
    d_illegal     = 1'b0;
    d_fin         = 1'b0;
    d_ld          = 1'b0;
    case (op)
      3'b000: begin
        d_opnd_sel = 1'b1;
        case (sub)
          3'b000: begin
            d_alu_op    = ALU_PASS_ACC;
            d_waddr_sel = 1'b1;
            d_write_en  = 1'b1;
            d_reset_acc = 1'b1;
          end
          3'b010: begin
            d_alu_op      = ALU_PASS_VAL;
            d_dm_write_en = 1'b1;
          end
          3'b011: begin
            d_alu_op   = ALU_PASS_VAL;
            d_wval_sel = 1'b1;
            d_write_en = 1'b1;
            d_ld       = 1'b1;
          end
          3'b100: begin
            d_alu_op   = ALU_DIST;
            d_write_en = 1'b1;
          end
          3'b101: begin
            d_alu_op   = ALU_MIN;
            d_write_en = 1'b1;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: begin
        // ADD..RSHFT map onto alu codes 2..6
        d_alu_op   = 4'(op) + 4'd1;
        d_write_en = 1'b1;
        d_opnd_sel = (sub == 3'b111);
      end
      3'b110: begin
        d_alu_op   = ALU_PASS_VAL;
        d_rel_jump = instr[IW-4] ? 1'b1 : cc_i;
      end
      default: begin
        case (sub)
          3'b000:  d_fin       = 1'b1;
          3'b001:  d_sys_reset = 1'b1;
          default: d_illegal   = 1'b1;
        endcase
      end
    endcase
    // Illegal encodings issue a harmless word rather than undefined control
    if (d_illegal) begin
      d_alu_op      = ALU_UNK;
      d_opnd_sel    = 1'b0;
      d_rel_jump    = 1'b0;
      d_waddr_sel   = 1'b0;
      d_wval_sel    = 1'b0;
      d_reset_acc   = 1'b0;
      d_write_en    = 1'b0;
      d_dm_write_en = 1'b0;
      d_sys_reset   = 1'b0;
    end
  end

  // Output register: load on accept, drop valid once consumed, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_op       <= ALU_PASS_ACC;
      alu_opnd_sel <= 1'b0;
      opnd         <= '0;
      rel_jump     <= 1'b0;
      rf_waddr_sel <= 1'b0;
      rf_wval_sel  <= 1'b0;
      rf_reset_acc <= 1'b0;
      rf_write_en  <= 1'b0;
      dm_write_en  <= 1'b0;
      sys_reset    <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      alu_op       <= d_alu_op;
      alu_opnd_sel <= d_opnd_sel;
      opnd         <= instr[IW-7:0];
      rel_jump     <= d_rel_jump;
      rf_waddr_sel <= d_waddr_sel;
      rf_wval_sel  <= d_wval_sel;
      rf_reset_acc <= d_reset_acc;
      rf_write_en  <= d_write_en;
      dm_write_en  <= d_dm_write_en;
      sys_reset    <= d_sys_reset;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky halt and illegal flags; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (accept && d_fin)     done    <= 1'b1;
      if (accept && d_illegal) illegal <= 1'b1;
    end
  end

  // Load-use bubble counter, free-running regardless of execute backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept && d_ld) begin
      stall_cnt <= SCW'(LD_STALL);
    end else if (stall_cnt != SCW'(0)) begin
      stall_cnt <= stall_cnt - SCW'(1);
    end
  end

endmodule
